// File: rtl/usb_reset_seq.sv
// Reset sequencer for the 60 MHz USB domain: synchronise PLL lock, wait for a
// stable lock, pulse the ULPI PHY reset, let the PHY settle, then release the core.
module usb_reset_seq #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int PHY_RST_CYCLES     = 600,
   parameter int PHY_WAIT_CYCLES    = 3000,
   parameter int CNT_W              = 16
) (
   input  logic       clk60mhz,
   input  logic       rst,
   input  logic       clk_locked,
   input  logic       sw_restart,
   output logic       phy_reset,
   output logic       core_reset,
   output logic       ready,
   output logic [7:0] lock_lost_cnt,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      PHY_RST   = 2'd1,
      PHY_WAIT  = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             lost_q, lost_d;
   logic                   phy_reset_q, core_reset_q, ready_q;
   logic                   lock_s;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lost_d  = lost_q;
      if (state_q == WAIT_LOCK) begin
         // Any low sample restarts the stability window from zero.
         if (!lock_s) begin
            cnt_d = '0;
         end else if (cnt_q == LOCK_LAST) begin
            state_d = PHY_RST;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (!lock_s) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end else if (sw_restart) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
      end else begin
         case (state_q)
            PHY_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = PHY_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PHY_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk60mhz or negedge rst) begin
      if (!rst) begin
         sync_q       <= '0;
         state_q      <= WAIT_LOCK;
         cnt_q        <= '0;
         lost_q       <= '0;
         phy_reset_q  <= 1'b1;
         core_reset_q <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], clk_locked};
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lost_q       <= lost_d;
         phy_reset_q  <= (state_d == WAIT_LOCK) || (state_d == PHY_RST);
         core_reset_q <= (state_d != RUN);
         ready_q      <= (state_d == RUN);
      end
   end

   assign phy_reset     = phy_reset_q;
   assign core_reset    = core_reset_q;
   assign ready         = ready_q;
   assign lock_lost_cnt = lost_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_usb_reset_seq.sv
// Bench for usb_reset_seq: a lock-streak reference model plus scenario tasks
// with directed edge-numbered checks and a randomized soak.
module tb_usb_reset_seq;

   localparam int S = 2;
   localparam int L = 8;
   localparam int R = 4;
   localparam int W = 6;

   logic       clk60mhz = 1'b0;
   logic       rst = 1'b0;
   logic       clk_locked = 1'b0;
   logic       sw_restart = 1'b0;
   logic       phy_reset, core_reset, ready;
   logic [7:0] lock_lost_cnt;
   logic [1:0] dbg_state;

   int total = 0;
   int bad = 0;

   usb_reset_seq #(
      .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .PHY_RST_CYCLES(R),
      .PHY_WAIT_CYCLES(W), .CNT_W(16)
   ) dut (
      .clk60mhz(clk60mhz), .rst(rst), .clk_locked(clk_locked), .sw_restart(sw_restart),
      .phy_reset(phy_reset), .core_reset(core_reset), .ready(ready),
      .lock_lost_cnt(lock_lost_cnt), .dbg_state(dbg_state)
   );

   always #5 clk60mhz = ~clk60mhz;

   // Reference: m_streak counts synchronised-high samples since the last restart;
   // the sequence phase follows from it by plain thresholds.
   logic [S-1:0] m_hist;
   int           m_streak;
   int           m_lost;

   always @(posedge clk60mhz or negedge rst) begin
      if (!rst) begin
         m_hist   <= '0;
         m_streak <= 0;
         m_lost   <= 0;
      end else begin
         m_hist <= {m_hist[S-2:0], clk_locked};
         if (!m_hist[S-1]) begin
            if (m_streak >= L && m_lost < 255) m_lost <= m_lost + 1;
            m_streak <= 0;
         end else if (sw_restart && m_streak >= L) begin
            m_streak <= 0;
         end else if (m_streak < 100000) begin
            m_streak <= m_streak + 1;
         end
      end
   end

   function automatic logic [10:0] exp_vec();
      return {m_streak < L + R, m_streak < L + R + W, m_streak >= L + R + W, 8'(m_lost)};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      clk_locked = 1'b1;
      sw_restart = 1'b0;
      repeat (3) @(negedge clk60mhz);
      total++;
      if ({phy_reset, core_reset, ready, lock_lost_cnt} !== {3'b110, 8'd0}) begin
         bad++;
         $display("FAIL reset_vals: got %b want %b", {phy_reset, core_reset, ready, lock_lost_cnt}, {3'b110, 8'd0});
      end
      rst = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, ready} !== {e < 14, e >= 20}) begin
            bad++;
            $display("FAIL reset_seq edge %0d: got phy=%b rdy=%b want phy=%b rdy=%b", e, phy_reset, ready, e < 14, e >= 20);
         end
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
            bad++;
            $display("FAIL reset_model edge %0d: got %b want %b", e, {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
         end
      end
   endtask

   task automatic test_glitch();
      rst = 1'b0;
      clk_locked = 1'b0;
      repeat (2) @(negedge clk60mhz);
      rst = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         clk_locked = (e != 5);
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, ready} !== {e < 19, e >= 25}) begin
            bad++;
            $display("FAIL glitch edge %0d: got phy=%b rdy=%b want phy=%b rdy=%b", e, phy_reset, ready, e < 19, e >= 25);
         end
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
            bad++;
            $display("FAIL glitch_model edge %0d: got %b want %b", e, {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
         end
      end
   endtask

   task automatic test_lock_loss();
      int budget = 40;
      clk_locked = 1'b1;
      while (!ready && budget > 0) begin
         @(negedge clk60mhz);
         budget--;
      end
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL loss_precond: got ready=%b want 1", ready);
      end
      clk_locked = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== ((e >= 3) ? {3'b110, 8'd1} : {3'b001, 8'd0})) begin
            bad++;
            $display("FAIL loss_run edge %0d: got %b", e, {phy_reset, core_reset, ready, lock_lost_cnt});
         end
      end
      clk_locked = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         @(negedge clk60mhz);
         total++;
         if ({ready, lock_lost_cnt} !== {e >= 20, 8'd1}) begin
            bad++;
            $display("FAIL relock edge %0d: got rdy=%b lost=%0d want rdy=%b lost=1", e, ready, lock_lost_cnt, e >= 20);
         end
      end
   endtask

   task automatic test_sw_restart();
      rst = 1'b0;
      clk_locked = 1'b1;
      repeat (2) @(negedge clk60mhz);
      rst = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         sw_restart = (e == 17) || (e == 20);
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, ready, lock_lost_cnt} !== {(e < 14) || (e >= 17 && e < 29), e >= 35, 8'd0}) begin
            bad++;
            $display("FAIL sw_restart edge %0d: got phy=%b rdy=%b lost=%0d want phy=%b rdy=%b lost=0",
                     e, phy_reset, ready, lock_lost_cnt, (e < 14) || (e >= 17 && e < 29), e >= 35);
         end
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
            bad++;
            $display("FAIL sw_model edge %0d: got %b want %b", e, {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
         end
      end
      sw_restart = 1'b0;
   endtask

   task automatic test_simul_sat();
      clk_locked = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         sw_restart = (e == 3);
         @(negedge clk60mhz);
         total++;
         if ({ready, lock_lost_cnt} !== {e < 3, (e >= 3) ? 8'd1 : 8'd0}) begin
            bad++;
            $display("FAIL simul edge %0d: got rdy=%b lost=%0d want rdy=%b lost=%0d", e, ready, lock_lost_cnt, e < 3, (e >= 3) ? 1 : 0);
         end
      end
      sw_restart = 1'b0;
      for (int n = 0; n < 300; n++) begin
         for (int e = 1; e <= 15; e++) begin
            clk_locked = (e <= 12);
            @(negedge clk60mhz);
            total++;
            if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
               bad++;
               $display("FAIL sat_model loss %0d edge %0d: got %b want %b", n, e, {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
            end
         end
      end
      total++;
      if (lock_lost_cnt !== 8'd255) begin
         bad++;
         $display("FAIL saturate: got %0d want 255", lock_lost_cnt);
      end
   endtask

   task automatic test_mid_reset();
      int budget = 40;
      clk_locked = 1'b1;
      while (m_streak != L + 2 && budget > 0) begin
         @(negedge clk60mhz);
         budget--;
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
            bad++;
            $display("FAIL mid_pre_model: got %b want %b", {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
         end
      end
      total++;
      if (m_streak != L + 2 || lock_lost_cnt !== 8'd255) begin
         bad++;
         $display("FAIL mid_precond: got lost=%0d streak=%0d want lost=255 streak=%0d", lock_lost_cnt, m_streak, L + 2);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({phy_reset, core_reset, ready, lock_lost_cnt} !== {3'b110, 8'd0}) begin
         bad++;
         $display("FAIL mid_async: got %b want %b", {phy_reset, core_reset, ready, lock_lost_cnt}, {3'b110, 8'd0});
      end
      @(negedge clk60mhz);
      rst = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, ready, lock_lost_cnt} !== {e < 14, e >= 20, 8'd0}) begin
            bad++;
            $display("FAIL mid_reseq edge %0d: got phy=%b rdy=%b lost=%0d want phy=%b rdy=%b lost=0",
                     e, phy_reset, ready, lock_lost_cnt, e < 14, e >= 20);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if (clk_locked) clk_locked = ($urandom_range(0, 99) >= 3);
         else            clk_locked = ($urandom_range(0, 99) < 30);
         sw_restart = ($urandom_range(0, 99) < 5);
         @(negedge clk60mhz);
         total++;
         if ({phy_reset, core_reset, ready, lock_lost_cnt} !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc %0d: got %b want %b", i, {phy_reset, core_reset, ready, lock_lost_cnt}, exp_vec());
         end
      end
      sw_restart = 1'b0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_lock_loss();
      test_sw_restart();
      test_simul_sat();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/usb_reset_seq.md
# usb_reset_seq

Reset sequencer for the 60 MHz USB clock domain, directly downstream of the Gowin rPLL. Synchronises the PLL lock flag and waits for a stable lock. Then pulses the ULPI PHY reset, holds the USB core in reset while the PHY settles, and finally releases the core. Any loss of lock or software restart sends the block back to the start of the sequence and forces both resets.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on `clk_locked`; minimum 2.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high samples required; minimum 1.
- PHY_RST_CYCLES, 600: length of the `phy_reset` pulse in the PHY_RST state (10 µs at 60 MHz); minimum 1.
- PHY_WAIT_CYCLES, 3000: PHY settle time before core release; minimum 1.
- CNT_W, 16: width of the shared sequence counter; must hold max(L, R, W) − 1.

Ports:
- clk60mhz  input  1  sole clock; PLL output.
- rst  input  1  asynchronous, active-low reset for all flops.
- clk_locked  input  1  PLL lock; asynchronous to clk60mhz.
- sw_restart  input  1  synchronous single-cycle restart request.
- phy_reset  output  1  active-high reset to the ULPI PHY.
- core_reset  output  1  active-high reset to the USB core.
- ready  output  1  high only in RUN.
- lock_lost_cnt  output  8  saturating count of lock losses after leaving WAIT_LOCK.

## Operation
- `lock_s` is `clk_locked` after SYNC_STAGES flops. The synchroniser flops reset to 0.
- States:
  - WAIT_LOCK (reset state)
  - PHY_RST
  - PHY_WAIT
  - RUN
- Outputs are registered and decoded from the state register:
  - `phy_reset` = WAIT_LOCK or PHY_RST.
  - `core_reset` = not RUN.
  - `ready` = RUN.
- Reset values:
  - state = WAIT_LOCK, counter = 0, synchroniser = 0.
  - `phy_reset` = 1, `core_reset` = 1, `ready` = 0, `lock_lost_cnt` = 0.
- WAIT_LOCK:
  - The counter increments on each `lock_s` = 1 and clears to 0 on any `lock_s` = 0.
  - When `lock_s` = 1 and counter = LOCK_STABLE_CYCLES−1, go to PHY_RST and clear the counter.
  - `sw_restart` is ignored in this state.
- PHY_RST: the counter increments. At PHY_RST_CYCLES−1, go to PHY_WAIT and clear the counter.
- PHY_WAIT: the counter increments. At PHY_WAIT_CYCLES−1, go to RUN and clear the counter.
- RUN: the counter holds at 0.
- Abort from PHY_RST, PHY_WAIT or RUN:
  - `lock_s` = 0: go to WAIT_LOCK, clear the counter, and increment `lock_lost_cnt` (saturates at 255).
  - `sw_restart` = 1 with `lock_s` = 1: go to WAIT_LOCK and clear the counter; `lock_lost_cnt` is unchanged.
  - Both in the same cycle: treated as lock loss, so the count increments once.
  - An abort has priority over the normal counter-terminal transition in the same cycle.
- Asserting `rst` at any time immediately (asynchronously) forces all reset values, including `lock_lost_cnt` = 0.
- Releasing `rst` restarts the sequence from WAIT_LOCK with an empty synchroniser.

## Timing
- Synchroniser latency: `lock_s` follows `clk_locked` SYNC_STAGES rising edges after the pin changes (with the pin stable for at least a setup window).
- Let S, L, R, W be SYNC_STAGES, LOCK_STABLE_CYCLES, PHY_RST_CYCLES and PHY_WAIT_CYCLES.
- Number clock edges from 1, where edge 1 is the first edge to sample `clk_locked` = 1. With lock held high and no restart:
  - `phy_reset` stays 1 through edge S+L+R−1.
  - `phy_reset` falls after edge S+L+R.
  - `core_reset` falls and `ready` rises after edge S+L+R+W.
- PHY_RST occupies exactly R cycles; PHY_WAIT occupies exactly W cycles.
- On abort:
  - The state is WAIT_LOCK after the edge that samples `lock_s` = 0 or `sw_restart` = 1.
  - `phy_reset` and `core_reset` are 1, and `ready` is 0, from that edge onward.
  - Worst-case assertion delay after the `clk_locked` pin falls is S+1 edges.
- A lock glitch shorter than the stable window during WAIT_LOCK restarts the full L count.
- No output glitches: all outputs come from flops.

## Test plan
Bench parameters: S=2, L=8, R=4, W=6.

- Reset sequence: hold `rst`=0, then release with `clk_locked`=1 from time 0.
  - During reset: `phy_reset`=1, `core_reset`=1, `ready`=0, `lock_lost_cnt`=0.
  - After release: `phy_reset` falls after edge 14; `ready` rises after edge 20.
- Lock glitch: raise lock, drop it for 1 cycle at edge 5, raise again.
  - The counter restarts; `ready` rises 20 edges after the re-rise sample, with no early release.
- Lock loss in RUN: drop `clk_locked` while `ready`=1.
  - By edge S+1: `ready`=0, both resets = 1, `lock_lost_cnt`=1.
  - Re-lock: `ready` returns after 20 edges.
- Software restart: pulse `sw_restart` in PHY_WAIT (lock high).
  - Next cycle: WAIT_LOCK, `phy_reset`=1, `lock_lost_cnt` unchanged.
  - A `sw_restart` pulse in WAIT_LOCK has no effect.
- Simultaneous events and saturation: assert `sw_restart` in the same cycle `lock_s` falls in RUN.
  - `lock_lost_cnt` increments by exactly 1.
  - Repeat 300 lock losses: `lock_lost_cnt` saturates at 255.
- Mid-sequence reset: assert `rst` in PHY_RST at counter=2.
  - All outputs return to reset values asynchronously, with `lock_lost_cnt`=0.
  - After release: the full 20-edge sequence repeats.
